// File: rtl/fsoc_wb_uart_tx_if.sv
// Wishbone slave bus bundle for the fsoc UART transmitter.
// The master drives the request fields; the slave returns read data and acknowledge.
interface fsoc_wb_uart_tx_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [1:0]  adr;
  logic [3:0]  be;
  logic [31:0] dat_wr;
  logic [31:0] dat_rd;
  logic        ack;

  modport master (
    output cyc, stb, we, adr, be, dat_wr,
    input  dat_rd, ack
  );

  modport slave (
    input  cyc, stb, we, adr, be, dat_wr,
    output dat_rd, ack
  );
endinterface

// File: rtl/fsoc_wb_uart_tx.sv
// Wishbone UART transmitter: bytes written to DATA queue in a TX FIFO and leave tx_o as 8N1 frames.
// Define FSOC_UART_TX_IRQ_EN to add the CTRL.ie bit and the registered TX-done irq_o output.
module fsoc_wb_uart_tx #(
  parameter int CLKDIV    = 217,
  parameter int FIFODEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fsoc_wb_uart_tx_if.slave wb,
`ifdef FSOC_UART_TX_IRQ_EN
  output logic             irq_o,
`endif
  output logic             tx_o
);

  localparam int PTRW = $clog2(FIFODEPTH);
  localparam int CNTW = PTRW + 1;
  localparam int DIVW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLKDIV - 1);
  localparam logic [CNTW-1:0] DEPTH    = CNTW'(FIFODEPTH);

  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
`ifdef FSOC_UART_TX_IRQ_EN
  localparam logic [1:0] ADR_CTRL   = 2'd2;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]      mem [FIFODEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [CNTW-1:0] count;
  logic            ovf;

  logic [7:0]      shift;
  logic [2:0]      bit_cnt;
  logic [DIVW-1:0] div_cnt;

  logic            ack;
  logic [31:0]     dat_rd;

  logic            req;
  logic            data_wr;
  logic            status_rd;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic            busy;
  logic            bit_end;
  logic [31:0]     status_word;
  logic [31:0]     ctrl_word;
  logic [31:0]     read_word;

  // Upper byte lanes and data bits beyond the low byte carry nothing for this block.
  logic unused_bus;
  assign unused_bus = ^{wb.be[3:1], wb.dat_wr[31:8]};

  // Holding stb through the ack cycle must not start a second access.
  assign req       = wb.cyc & wb.stb & ~ack;
  assign data_wr   = req & wb.we & (wb.adr == ADR_DATA) & wb.be[0];
  assign status_rd = req & ~wb.we & (wb.adr == ADR_STATUS);

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign busy    = (state != S_IDLE);
  assign bit_end = (div_cnt == DIV_LAST);

  assign push = data_wr & ~full;
  assign pop  = ~empty & ((state == S_IDLE) | ((state == S_STOP) & bit_end));

  assign status_word = {16'h0000, 8'(count), 4'h0, ovf, empty, full, busy};

  always_comb begin
    read_word = 32'h0000_0000;
    case (wb.adr)
      ADR_STATUS: read_word = status_word;
      2'd2:       read_word = ctrl_word;
      default:    read_word = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack    <= 1'b0;
      dat_rd <= 32'h0000_0000;
    end else begin
      ack    <= req;
      dat_rd <= (req & ~wb.we) ? read_word : 32'h0000_0000;
    end
  end

  assign wb.ack    = ack;
  assign wb.dat_rd = dat_rd;

  // FIFO storage needs no reset: occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= wb.dat_wr[7:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (data_wr & full) begin
        ovf <= 1'b1;
      end else if (status_rd) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_START;
      S_START: if (bit_end) state_nxt = S_DATA;
      S_DATA:  if (bit_end && (bit_cnt == 3'd7)) state_nxt = S_STOP;
      S_STOP:  if (bit_end) state_nxt = empty ? S_IDLE : S_START;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_o = 1'b1;
    case (state)
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = shift[0];
      S_STOP:  tx_o = 1'b1;
      default: tx_o = 1'b1;
    endcase
  end

  // The divider restarts at every bit boundary so each bit lasts exactly CLKDIV cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt <= '0;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
    end else begin
      if ((state == S_IDLE) || bit_end) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (state == S_START) begin
        bit_cnt <= 3'd0;
      end else if ((state == S_DATA) && bit_end) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (pop) begin
        shift <= mem[rd_ptr];
      end else if ((state == S_DATA) && bit_end) begin
        shift <= {1'b0, shift[7:1]};
      end
    end
  end

`ifdef FSOC_UART_TX_IRQ_EN
  logic ie;
  logic ctrl_wr;
  logic irq;

  assign ctrl_wr   = req & wb.we & (wb.adr == ADR_CTRL) & wb.be[0];
  assign ctrl_word = {31'h0000_0000, ie};

  // A push or an ie clear drops the interrupt on the same edge rather than one cycle late.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ie <= wb.dat_wr[0];
      end
      irq <= ie & empty & (state == S_IDLE) & ~data_wr & ~(ctrl_wr & ~wb.dat_wr[0]);
    end
  end

  assign irq_o = irq;
`else
  assign ctrl_word = 32'h0000_0000;
`endif

endmodule
